// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding,
// reset constants and PC arithmetic.
package instr_fetch_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } if_state_e;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam logic [31:0] PC_RST   = 32'h0000_0000;

  // Word-address increment; wraps modulo 2^32.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd1;
  endfunction

endpackage

// File: rtl/instr_fetch_hold_buf.sv
// One-entry buffer holding an instruction word and its PC+1 when memory
// completes while decode is stalled.
module if_hold_buf
  import instr_fetch_pkg::*;
(
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] instr_d,
  input  logic [31:0] pc_m1_d,
  output logic [31:0] instr_q,
  output logic [31:0] pc_m1_q
);

  // Clear wins over load so a redirect always discards the entry.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= NOP_WORD;
      pc_m1_q <= PC_RST;
    end else if (clear) begin
      instr_q <= NOP_WORD;
      pc_m1_q <= PC_RST;
    end else if (load) begin
      instr_q <= instr_d;
      pc_m1_q <= pc_m1_d;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues word reads to instruction memory and
// delivers one instruction per cycle to decode, handling memory wait
// states, decode stalls and branch redirects.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_FETCH | idle or streaming; request PC when not stalled/redirected
// ST_WAIT  | request outstanding, memory not ready yet
// ST_HOLD  | response captured in hold buffer while decode stalled
// ST_DRAIN | redirect pending; old request must complete before reuse
module instr_fetch
  import instr_fetch_pkg::*;
(
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] pc_m1,
  output logic [31:0] ir,
  output logic        valid
);

  if_state_e   state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] redir, redir_nxt;
  logic [31:0] ir_nxt, pc_m1_nxt;
  logic        valid_nxt;
  logic        buf_load, buf_clear;
  logic [31:0] buf_instr, buf_pc_m1;

  if_hold_buf u_hold_buf (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .load    (buf_load),
    .clear   (buf_clear),
    .instr_d (imem_rdata),
    .pc_m1_d (pc_inc(pc)),
    .instr_q (buf_instr),
    .pc_m1_q (buf_pc_m1)
  );

  // Request is combinational from state; reset gates it off immediately.
  assign imem_req  = rst_n & (((state == ST_FETCH) & ~stall & ~br_taken) |
                              (state == ST_WAIT) | (state == ST_DRAIN));
  assign imem_addr = pc;

  // State register.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) state <= ST_FETCH;
    else        state <= state_nxt;
  end

  // Next-state and datapath control; default is to hold everything.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    redir_nxt = redir;
    ir_nxt    = ir;
    pc_m1_nxt = pc_m1;
    valid_nxt = valid;
    buf_load  = 1'b0;
    buf_clear = 1'b0;
    case (state)
      ST_FETCH: begin
        if (br_taken) begin
          pc_nxt    = br_target;
          ir_nxt    = NOP_WORD;
          valid_nxt = 1'b0;
        end else if (!stall) begin
          if (imem_ready) begin
            ir_nxt    = imem_rdata;
            pc_m1_nxt = pc_inc(pc);
            valid_nxt = 1'b1;
            pc_nxt    = pc_inc(pc);
          end else begin
            ir_nxt    = NOP_WORD;
            valid_nxt = 1'b0;
            state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (br_taken) begin
          ir_nxt    = NOP_WORD;
          valid_nxt = 1'b0;
          if (imem_ready) begin
            pc_nxt    = br_target;
            state_nxt = ST_FETCH;
          end else begin
            // Address must stay put until the old request completes.
            redir_nxt = br_target;
            state_nxt = ST_DRAIN;
          end
        end else if (imem_ready) begin
          pc_nxt = pc_inc(pc);
          if (stall) begin
            buf_load  = 1'b1;
            state_nxt = ST_HOLD;
          end else begin
            ir_nxt    = imem_rdata;
            pc_m1_nxt = pc_inc(pc);
            valid_nxt = 1'b1;
            state_nxt = ST_FETCH;
          end
        end else if (!stall) begin
          ir_nxt    = NOP_WORD;
          valid_nxt = 1'b0;
        end
      end
      ST_HOLD: begin
        if (br_taken) begin
          pc_nxt    = br_target;
          buf_clear = 1'b1;
          ir_nxt    = NOP_WORD;
          valid_nxt = 1'b0;
          state_nxt = ST_FETCH;
        end else if (!stall) begin
          ir_nxt    = buf_instr;
          pc_m1_nxt = buf_pc_m1;
          valid_nxt = 1'b1;
          state_nxt = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (br_taken) begin
          ir_nxt    = NOP_WORD;
          valid_nxt = 1'b0;
          if (imem_ready) begin
            pc_nxt    = br_target;
            state_nxt = ST_FETCH;
          end else begin
            redir_nxt = br_target;
          end
        end else begin
          if (!stall) begin
            ir_nxt    = NOP_WORD;
            valid_nxt = 1'b0;
          end
          if (imem_ready) begin
            pc_nxt    = redir;
            state_nxt = ST_FETCH;
          end
        end
      end
      default: state_nxt = ST_FETCH;
    endcase
  end

  // PC, redirect target and decode-facing output registers.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= PC_RST;
      redir <= PC_RST;
      ir    <= NOP_WORD;
      pc_m1 <= PC_RST;
      valid <= 1'b0;
    end else begin
      pc    <= pc_nxt;
      redir <= redir_nxt;
      ir    <= ir_nxt;
      pc_m1 <= pc_m1_nxt;
      valid <= valid_nxt;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: the bench acts as instruction memory
// (rdata = addr*4), tracks the expected fetch address and request, and
// scoreboards every accepted word against what decode receives.
module tb_instr_fetch;

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic        stall, br_taken, imem_ready;
  logic [31:0] br_target;
  logic        imem_req;
  logic [31:0] imem_addr, imem_rdata, pc_m1, ir;
  logic        valid;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [31:0] ir;
    logic [31:0] pcm1;
  } exp_t;
  exp_t sb_q[$];

  logic [31:0] exp_pc  = 32'h0;
  logic [31:0] exp_red = 32'h0;
  logic        exp_drain = 1'b0;
  logic        exp_out   = 1'b0;
  logic        exp_req   = 1'b0;

  logic        p_rst, p_stall, p_br, p_rdy, p_valid;
  logic [31:0] p_tgt, p_ir, p_pcm1;

  instr_fetch dut (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .pc_m1      (pc_m1),
    .ir         (ir),
    .valid      (valid)
  );

  always #5 clk_sys = ~clk_sys;

  assign imem_rdata = imem_addr << 2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  task automatic drive(input logic s, input logic b, input logic r, input logic [31:0] t);
    stall      = s;
    br_taken   = b;
    imem_ready = r;
    br_target  = t;
    @(posedge clk_sys);
    #2;
  endtask

  // Scoreboard monitor: sample before the edge, check after it.
  initial begin
    forever begin
      @(negedge clk_sys);
      p_rst   = rst_n;
      p_stall = stall;
      p_br    = br_taken;
      p_tgt   = br_target;
      p_rdy   = imem_ready;
      p_ir    = ir;
      p_pcm1  = pc_m1;
      p_valid = valid;
      if (rst_n === 1'b1) begin
        exp_req = (sb_q.size() == 0) && (exp_out || (!stall && !br_taken));
        chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
        if (exp_req) chk("imem_addr", imem_addr, exp_pc);
      end
      @(posedge clk_sys);
      #1;
      if (p_rst !== 1'b1 || rst_n !== 1'b1) begin
        exp_pc    = 32'h0;
        exp_red   = 32'h0;
        exp_drain = 1'b0;
        exp_out   = 1'b0;
        exp_req   = 1'b0;
        sb_q.delete();
      end else if (p_br) begin
        if (exp_req && !p_rdy) begin
          exp_red   = p_tgt;
          exp_drain = 1'b1;
          exp_out   = 1'b1;
        end else begin
          exp_pc    = p_tgt;
          exp_drain = 1'b0;
          exp_out   = 1'b0;
        end
        sb_q.delete();
        chk("br_valid", {31'b0, valid}, 32'h0);
        chk("br_ir", ir, 32'h0);
      end else begin
        if (exp_req && p_rdy) begin
          if (exp_drain) begin
            exp_pc    = exp_red;
            exp_drain = 1'b0;
          end else begin
            sb_q.push_back('{32'(exp_pc << 2), 32'(exp_pc + 32'd1)});
            exp_pc = 32'(exp_pc + 32'd1);
          end
        end
        exp_out = exp_req && !p_rdy;
        if (p_stall) begin
          chk("stall_ir", ir, p_ir);
          chk("stall_pc_m1", pc_m1, p_pcm1);
          chk("stall_valid", {31'b0, valid}, {31'b0, p_valid});
        end else if (sb_q.size() > 0) begin
          exp_t e;
          e = sb_q.pop_front();
          chk("deliver_valid", {31'b0, valid}, 32'h1);
          chk("deliver_ir", ir, e.ir);
          chk("deliver_pc_m1", pc_m1, e.pcm1);
        end else begin
          chk("bubble_valid", {31'b0, valid}, 32'h0);
          chk("bubble_ir", ir, 32'h0);
        end
      end
    end
  end

  // Directed scenarios followed by a random run.
  initial begin
    stall = 1'b0; br_taken = 1'b0; imem_ready = 1'b1; br_target = 32'h0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_ir", ir, 32'h0);
    chk("rst_pc_m1", pc_m1, 32'h0);
    chk("rst_valid", {31'b0, valid}, 32'h0);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    repeat (3) @(posedge clk_sys);
    #2 rst_n = 1'b1;
    #1;
    chk("first_req", {31'b0, imem_req}, 32'h1);
    chk("first_addr", imem_addr, 32'h0);

    // Streaming with memory always ready.
    repeat (3) drive(0, 0, 1, 0);
    chk("stream_ir", ir, 32'h8);
    chk("stream_pc_m1", pc_m1, 32'h3);

    // Wait states at address 2.
    drive(0, 1, 1, 32'h2);
    repeat (3) drive(0, 0, 0, 0);
    chk("wait_addr", imem_addr, 32'h2);
    drive(0, 0, 1, 0);
    chk("wait_ir", ir, 32'h8);
    chk("wait_pc_m1", pc_m1, 32'h3);

    // Stall while the wait completes: hold buffer path.
    drive(0, 0, 0, 0);
    drive(1, 0, 0, 0);
    drive(1, 0, 1, 0);
    drive(1, 0, 1, 0);
    drive(0, 0, 1, 0);
    chk("hold_ir", ir, 32'hC);

    // Redirect during a wait, then a redirect overwritten while draining.
    drive(0, 0, 0, 0);
    drive(0, 1, 0, 32'h40);
    drive(0, 0, 0, 0);
    drive(0, 0, 1, 0);
    chk("drain_addr", imem_addr, 32'h40);
    drive(0, 0, 1, 0);
    chk("drain_ir", ir, 32'h100);
    drive(0, 0, 0, 0);
    drive(0, 1, 0, 32'h80);
    drive(0, 1, 0, 32'h90);
    drive(0, 0, 1, 0);
    chk("redir_ovw_addr", imem_addr, 32'h90);

    // Redirect with stall while holding a buffered word.
    drive(0, 0, 0, 0);
    drive(1, 0, 1, 0);
    drive(1, 1, 1, 32'h200);
    chk("hold_br_addr", imem_addr, 32'h200);
    chk("hold_br_valid", {31'b0, valid}, 32'h0);
    drive(0, 0, 1, 0);
    chk("hold_br_ir", ir, 32'h800);

    // PC wrap at the top of the address space.
    drive(0, 1, 1, 32'hFFFF_FFFE);
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);
    chk("wrap_pc_m1", pc_m1, 32'h0);
    drive(0, 0, 1, 0);
    chk("wrap_ir", ir, 32'h0);

    // Random mix of stalls, wait states and redirects.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(3) == 0), ($urandom_range(15) == 0),
            ($urandom_range(2) != 0), $urandom);
    end
    repeat (3) drive(0, 0, 1, 0);
    chk("sb_empty", 32'(sb_q.size()), 32'h0);

    // Reset in the middle of a wait.
    drive(0, 1, 1, 32'h30);
    drive(0, 0, 0, 0);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_req", {31'b0, imem_req}, 32'h0);
    chk("midrst_addr", imem_addr, 32'h0);
    chk("midrst_ir", ir, 32'h0);
    chk("midrst_pc_m1", pc_m1, 32'h0);
    chk("midrst_valid", {31'b0, valid}, 32'h0);
    imem_ready = 1'b1;
    repeat (2) @(posedge clk_sys);
    #2 rst_n = 1'b1;
    #1;
    chk("rerst_addr", imem_addr, 32'h0);
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);
    chk("rerst_ir", ir, 32'h4);
    repeat (2) drive(0, 0, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
